// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus receiver.
//   - FSM state encoding
//   - instruction opcode masks (each mask is the highest set bit of its group)
//   - display character / address constants
//   - DDRAM index helper
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_BUSY  = 2'd2
  } lcd_state_e;

  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPLAY = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  localparam logic [7:0] SPACE_CODE = 8'h20;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] AC_MASK    = 7'h4F;

  localparam int CNT_W  = 17;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  // Visible address {line, column} -> physical cell index.
  function automatic logic [ADDR_W-1:0] ddram_index(input logic [6:0] addr);
    return {addr[6], addr[3:0]};
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 display data RAM.
//   clk_i                     : clock
//   we_i/waddr_i/wdata_i      : synchronous write port
//   raddr_a_i -> rdata_a_o    : registered read port (bus read-back)
//   raddr_b_i -> rdata_b_o    : registered read port (mirror)
// Reads return the contents before a same-cycle write to the same cell.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_a_o <= mem_q[raddr_a_i];
    rdata_b_o <= mem_q[raddr_b_i];
  end

endmodule

// File: rtl/lcd_bus_receiver.sv
// Receiver side of an HD44780-style character LCD bus.
// The controller drives RS/RW/E/DB asynchronously; every bus cycle is acted
// on at the synchronised falling edge of E.
//   clock50MHz, reset (sync, active-low)
//   RS, RW, E, DB           : controller bus inputs
//   DB_out, DB_oe           : read-back data and drive enable
//   busy, ac                : busy flag and address counter
//   display_on .. two_line  : decoded mode registers
//   rd_addr -> rd_data      : registered mirror read of DDRAM
//   cmd_strobe, err_busy    : one-cycle pulses (write accepted / write dropped)
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int BUSY_SHORT = 2000,
  parameter int BUSY_LONG  = 82000
) (
  input  logic              clock50MHz,
  input  logic              reset,
  input  logic              RS,
  input  logic              RW,
  input  logic              E,
  input  logic [7:0]        DB,
  output logic [7:0]        DB_out,
  output logic              DB_oe,
  output logic              busy,
  output logic [6:0]        ac,
  output logic              display_on,
  output logic              cursor_on,
  output logic              blink_on,
  output logic              inc_mode,
  output logic              two_line,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              cmd_strobe,
  output logic              err_busy
);

  localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(BUSY_SHORT - 1);
  localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(BUSY_LONG - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = '1;

  // Address counter step with wrap between the two 16-column lines.
  function automatic logic [6:0] step_ac(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == (LINE2_BASE | 7'h0F))  r = 7'h00;
      else if (a == 7'h0F)            r = LINE2_BASE;
      else                            r = a + 7'd1;
    end else begin
      if (a == 7'h00)                 r = LINE2_BASE | 7'h0F;
      else if (a == LINE2_BASE)       r = 7'h0F;
      else                            r = a - 7'd1;
    end
    return r;
  endfunction

  function automatic logic has(input logic [7:0] v, input logic [7:0] mask);
    return (v & mask) != 8'h00;
  endfunction

  logic             e_s1_q, e_s2_q, e_s3_q;
  logic             rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
  logic [7:0]       db_s1_q, db_s2_q;

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [6:0]       ac_q, ac_d;
  logic             inc_q, inc_d, disp_q, disp_d, cur_q, cur_d;
  logic             blink_q, blink_d, two_q, two_d;
  logic             oe_q, oe_d, strobe_q, strobe_d, err_q, err_d;
  logic [7:0]       dbo_q, dbo_d;

  logic             mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rdata_a;

  logic             busy_w, e_fall, wr_acc;

  assign busy_w = (state_q != ST_IDLE);
  assign e_fall = e_s3_q & ~e_s2_q;
  assign wr_acc = e_fall & ~rw_s2_q;

  lcd_ddram u_ddram (
    .clk_i     (clock50MHz),
    .we_i      (mem_we),
    .waddr_i   (mem_waddr),
    .wdata_i   (mem_wdata),
    .raddr_a_i (ddram_index(ac_q)),
    .rdata_a_o (rdata_a),
    .raddr_b_i (rd_addr),
    .rdata_b_o (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ac_d      = ac_q;
    inc_d     = inc_q;
    disp_d    = disp_q;
    cur_d     = cur_q;
    blink_d   = blink_q;
    two_d     = two_q;
    strobe_d  = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ddram_index(ac_q);
    mem_wdata = db_s2_q;

    // Read-back is serviced in every state, busy or not.
    oe_d  = e_s2_q & rw_s2_q;
    dbo_d = 8'h00;
    if (oe_d) begin
      dbo_d = rs_s2_q ? rdata_a : {busy_w, ac_q};
    end
    if (e_fall && rw_s2_q && rs_s2_q) begin
      ac_d = step_ac(ac_q, inc_q);
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_acc) begin
          strobe_d = 1'b1;
          state_d  = ST_BUSY;
          cnt_d    = SHORT_LOAD;
          if (rs_s2_q) begin
            mem_we = 1'b1;
            ac_d   = step_ac(ac_q, inc_q);
          end else if (has(db_s2_q, OP_DDRAM)) begin
            ac_d = db_s2_q[6:0] & AC_MASK;
          end else if (has(db_s2_q, OP_CGRAM)) begin
            ac_d = ac_q;
          end else if (has(db_s2_q, OP_FUNC)) begin
            two_d = db_s2_q[3];
          end else if (has(db_s2_q, OP_SHIFT)) begin
            ac_d = ac_q;
          end else if (has(db_s2_q, OP_DISPLAY)) begin
            disp_d  = db_s2_q[2];
            cur_d   = db_s2_q[1];
            blink_d = db_s2_q[0];
          end else if (has(db_s2_q, OP_ENTRY)) begin
            inc_d = db_s2_q[1];
          end else if (has(db_s2_q, OP_HOME)) begin
            ac_d  = 7'h00;
            cnt_d = LONG_LOAD;
          end else if (has(db_s2_q, OP_CLEAR)) begin
            ac_d    = 7'h00;
            inc_d   = 1'b1;
            idx_d   = '0;
            state_d = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = SPACE_CODE;
        idx_d     = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_BUSY;
          cnt_d   = LONG_LOAD;
        end
        err_d = wr_acc;
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
        err_d = wr_acc;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock50MHz) begin
    if (!reset) begin
      e_s1_q   <= 1'b0;
      e_s2_q   <= 1'b0;
      e_s3_q   <= 1'b0;
      rs_s1_q  <= 1'b0;
      rs_s2_q  <= 1'b0;
      rw_s1_q  <= 1'b0;
      rw_s2_q  <= 1'b0;
      db_s1_q  <= 8'h00;
      db_s2_q  <= 8'h00;
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      idx_q    <= '0;
      ac_q     <= 7'h00;
      inc_q    <= 1'b1;
      disp_q   <= 1'b0;
      cur_q    <= 1'b0;
      blink_q  <= 1'b0;
      two_q    <= 1'b0;
      oe_q     <= 1'b0;
      dbo_q    <= 8'h00;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      e_s1_q   <= E;
      e_s2_q   <= e_s1_q;
      e_s3_q   <= e_s2_q;
      rs_s1_q  <= RS;
      rs_s2_q  <= rs_s1_q;
      rw_s1_q  <= RW;
      rw_s2_q  <= rw_s1_q;
      db_s1_q  <= DB;
      db_s2_q  <= db_s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ac_q     <= ac_d;
      inc_q    <= inc_d;
      disp_q   <= disp_d;
      cur_q    <= cur_d;
      blink_q  <= blink_d;
      two_q    <= two_d;
      oe_q     <= oe_d;
      dbo_q    <= dbo_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  assign DB_out     = dbo_q;
  assign DB_oe      = oe_q;
  assign busy       = busy_w;
  assign ac         = ac_q;
  assign display_on = disp_q;
  assign cursor_on  = cur_q;
  assign blink_on   = blink_q;
  assign inc_mode   = inc_q;
  assign two_line   = two_q;
  assign cmd_strobe = strobe_q;
  assign err_busy   = err_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver with short busy times.
module tb_lcd_bus_receiver;

  localparam int BS = 4;
  localparam int BL = 10;

  logic       clk;
  logic       reset, RS, RW, E;
  logic [7:0] DB, DB_out, rd_data;
  logic       DB_oe, busy, display_on, cursor_on, blink_on, inc_mode, two_line;
  logic [6:0] ac;
  logic [4:0] rd_addr;
  logic       cmd_strobe, err_busy;

  lcd_bus_receiver #(.BUSY_SHORT(BS), .BUSY_LONG(BL)) dut (
    .clock50MHz (clk),
    .reset      (reset),
    .RS         (RS),
    .RW         (RW),
    .E          (E),
    .DB         (DB),
    .DB_out     (DB_out),
    .DB_oe      (DB_oe),
    .busy       (busy),
    .ac         (ac),
    .display_on (display_on),
    .cursor_on  (cursor_on),
    .blink_on   (blink_on),
    .inc_mode   (inc_mode),
    .two_line   (two_line),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cmd_strobe (cmd_strobe),
    .err_busy   (err_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int strobe_cnt = 0;
  int err_cnt    = 0;

  always @(negedge clk) begin
    if (cmd_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
    if (err_busy === 1'b1)   err_cnt    <= err_cnt + 1;
  end

  typedef struct {
    logic       rs;
    logic [7:0] db;
    logic [6:0] ac;
    logic [4:0] modes;   // {display_on, cursor_on, blink_on, inc_mode, two_line}
    logic [4:0] caddr;
    logic [7:0] cdata;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [4:0] modes_now();
    return {display_on, cursor_on, blink_on, inc_mode, two_line};
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] db);
    @(negedge clk);
    RS = rs; RW = 1'b0; DB = db; E = 1'b1;
    repeat (3) @(negedge clk);
    E = 1'b0;
    repeat (4) @(negedge clk);
    wait_idle();
  endtask

  task automatic mirror(input logic [4:0] a, output logic [7:0] d);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] d;
    int         n;

    vecs[0]  = '{1'b0, 8'h0F, 7'h00, 5'b11110, 5'd0,  8'h20};
    vecs[1]  = '{1'b0, 8'h80, 7'h00, 5'b11110, 5'd0,  8'h20};
    vecs[2]  = '{1'b1, 8'h41, 7'h01, 5'b11110, 5'd0,  8'h41};
    vecs[3]  = '{1'b0, 8'h38, 7'h01, 5'b11111, 5'd0,  8'h41};
    vecs[4]  = '{1'b0, 8'h8F, 7'h0F, 5'b11111, 5'd15, 8'h20};
    vecs[5]  = '{1'b1, 8'h55, 7'h40, 5'b11111, 5'd15, 8'h55};
    vecs[6]  = '{1'b0, 8'h10, 7'h40, 5'b11111, 5'd15, 8'h55};
    vecs[7]  = '{1'b0, 8'h04, 7'h40, 5'b11101, 5'd15, 8'h55};
    vecs[8]  = '{1'b0, 8'h80, 7'h00, 5'b11101, 5'd0,  8'h41};
    vecs[9]  = '{1'b1, 8'h66, 7'h4F, 5'b11101, 5'd0,  8'h66};
    vecs[10] = '{1'b1, 8'h77, 7'h4E, 5'b11101, 5'd31, 8'h77};
    vecs[11] = '{1'b0, 8'hC5, 7'h45, 5'b11101, 5'd31, 8'h77};
    vecs[12] = '{1'b0, 8'h0A, 7'h45, 5'b01001, 5'd31, 8'h77};
    vecs[13] = '{1'b0, 8'h06, 7'h45, 5'b01011, 5'd21, 8'h20};
    vecs[14] = '{1'b1, 8'h12, 7'h46, 5'b01011, 5'd21, 8'h12};
    vecs[15] = '{1'b0, 8'h40, 7'h46, 5'b01011, 5'd21, 8'h12};
    vecs[16] = '{1'b0, 8'h03, 7'h00, 5'b01011, 5'd21, 8'h12};
    vecs[17] = '{1'b0, 8'h05, 7'h00, 5'b01001, 5'd21, 8'h12};
    vecs[18] = '{1'b0, 8'h01, 7'h00, 5'b01011, 5'd21, 8'h20};
    vecs[19] = '{1'b0, 8'h30, 7'h00, 5'b01010, 5'd0,  8'h20};
    vecs[20] = '{1'b0, 8'h04, 7'h00, 5'b01000, 5'd0,  8'h20};
    vecs[21] = '{1'b0, 8'hC0, 7'h40, 5'b01000, 5'd16, 8'h20};
    vecs[22] = '{1'b1, 8'h99, 7'h0F, 5'b01000, 5'd16, 8'h99};
    vecs[23] = '{1'b0, 8'hBA, 7'h0A, 5'b01000, 5'd16, 8'h99};

    reset = 1'b0; RS = 1'b0; RW = 1'b0; E = 1'b0; DB = 8'h00; rd_addr = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_ac_modes", {ac, modes_now()}, {7'h00, 5'b00010});
    check("rst_bus_pulses", {DB_oe, DB_out, cmd_strobe, err_busy}, 32'd0);

    reset = 1'b1;
    count_busy(n);
    check("rst_busy_len", n, 32 + BL);
    for (int i = 0; i < 32; i++) begin
      mirror(5'(i), d);
      check($sformatf("clr_cell%0d", i), d, 8'h20);
    end

    foreach (vecs[i]) begin
      bus_write(vecs[i].rs, vecs[i].db);
      check($sformatf("vec%0d_ac_modes", i), {ac, modes_now()}, {vecs[i].ac, vecs[i].modes});
      mirror(vecs[i].caddr, d);
      check($sformatf("vec%0d_cell", i), d, vecs[i].cdata);
    end
    @(negedge clk);
    check("strobe_count", strobe_cnt, 24);
    check("err_count_none", err_cnt, 0);

    // Data write landing while the previous instruction is still busy.
    @(negedge clk); RS = 1'b0; RW = 1'b0; DB = 8'h0C; E = 1'b1;
    @(negedge clk); E = 1'b0;
    @(negedge clk); RS = 1'b1; DB = 8'h77; E = 1'b1;
    @(negedge clk); E = 1'b0;
    repeat (5) @(negedge clk);
    wait_idle();
    @(negedge clk);
    check("err_strobe_count", strobe_cnt, 25);
    check("err_pulse_count", err_cnt, 1);
    check("err_ac_modes", {ac, modes_now()}, {7'h0A, 5'b10000});
    mirror(5'd10, d);
    check("err_cell_kept", d, 8'h20);

    // Instruction read during BUSY, then data read with auto-decrement.
    @(negedge clk); RS = 1'b0; RW = 1'b0; DB = 8'hC3; E = 1'b1;
    @(negedge clk); E = 1'b0;
    @(negedge clk); RW = 1'b1; E = 1'b1;
    repeat (3) @(negedge clk);
    check("ir_busy", {31'd0, busy}, 32'd1);
    check("ir_oe", {31'd0, DB_oe}, 32'd1);
    check("ir_data", DB_out, 8'hC3);
    E = 1'b0;
    repeat (4) @(negedge clk);
    wait_idle();
    check("ir_release", {DB_oe, DB_out}, 9'h000);
    check("ir_ac_kept", ac, 7'h43);

    @(negedge clk); RS = 1'b1; RW = 1'b1; E = 1'b1;
    repeat (4) @(negedge clk);
    check("dr_oe", {31'd0, DB_oe}, 32'd1);
    check("dr_data", DB_out, 8'h20);
    E = 1'b0;
    repeat (4) @(negedge clk);
    check("dr_ac_step", ac, 7'h42);
    check("dr_release", {DB_oe, DB_out}, 9'h000);
    RS = 1'b0; RW = 1'b0;

    // Reset in the middle of a clear sweep.
    @(negedge clk); RS = 1'b0; RW = 1'b0; DB = 8'h01; E = 1'b1;
    repeat (3) @(negedge clk);
    E = 1'b0;
    repeat (10) @(negedge clk);
    check("midclr_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midclr_rst_state", {ac, modes_now()}, {7'h00, 5'b00010});
    reset = 1'b1;
    count_busy(n);
    check("midclr_busy_len", n, 32 + BL);
    mirror(5'd15, d);
    check("midclr_cell15", d, 8'h20);
    mirror(5'd16, d);
    check("midclr_cell16", d, 8'h20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
